// File: rtl/lut_neuron_arbiter.sv
// Round-robin arbiter sharing one registered neuron LUT among NUM_REQ requesters.
// Each requester has at most one lookup outstanding. A lookup is either in the
// pipe or parked in that requester's result register.
module lut_neuron_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 2,
  parameter int LUT_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      lut_en,
  output logic [ADDR_W-1:0]         lut_addr,
  input  logic [DATA_W-1:0]         lut_data,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [NUM_REQ*DATA_W-1:0] rsp_data,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic                      busy
);

  localparam int TAG_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        eligible;
  logic                      grant_any;
  logic                      grant_fire;
  logic [TAG_W-1:0]          grant_idx;
  logic [TAG_W:0]            arb_sum;
  logic [TAG_W-1:0]          arb_idx;

  logic [TAG_W-1:0]          ptr_q, ptr_d;
  logic                      lut_en_q, lut_en_d;
  logic [ADDR_W-1:0]         lut_addr_q, lut_addr_d;
  logic [TAG_W-1:0]          issue_tag_q, issue_tag_d;

  // Tag pipe behind the issue register; the last stage lines up with lut_data.
  logic [LUT_LAT-1:0]        pipe_vld_q;
  logic [TAG_W-1:0]          pipe_tag_q [LUT_LAT];
  logic                      res_vld;
  logic [TAG_W-1:0]          res_tag;

  logic [NUM_REQ-1:0]        inflight_q, inflight_d;
  logic [NUM_REQ-1:0]        rsp_valid_q, rsp_valid_d;
  logic [NUM_REQ*DATA_W-1:0] rsp_data_q, rsp_data_d;

  // Per-requester eligibility and the one-hot grant.
  // The grant is suppressed while reset is held, so every output reads zero during reset.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign eligible[gi]  = req_valid[gi] & ~rsp_valid_q[gi] & ~inflight_q[gi];
    assign req_ready[gi] = rst & grant_any & (grant_idx == TAG_W'(gi));
  end

  assign grant_fire = rst & grant_any;
  assign res_vld    = pipe_vld_q[LUT_LAT-1];
  assign res_tag    = pipe_tag_q[LUT_LAT-1];

  // Rotating priority scan: first eligible requester starting at ptr, wrapping.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    arb_sum   = '0;
    arb_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      arb_sum = {1'b0, ptr_q} + (TAG_W+1)'(k);
      if (arb_sum >= (TAG_W+1)'(NUM_REQ)) begin
        arb_sum = arb_sum - (TAG_W+1)'(NUM_REQ);
      end
      arb_idx = arb_sum[TAG_W-1:0];
      if (!grant_any && eligible[arb_idx]) begin
        grant_any = 1'b1;
        grant_idx = arb_idx;
      end
    end
  end

  // Next state for the pointer, the LUT issue register and the result slots.
  always_comb begin
    ptr_d       = ptr_q;
    lut_en_d    = grant_fire;
    lut_addr_d  = lut_addr_q;
    issue_tag_d = issue_tag_q;
    inflight_d  = inflight_q;
    rsp_valid_d = rsp_valid_q & ~rsp_ready;
    rsp_data_d  = rsp_data_q;
    if (grant_fire) begin
      ptr_d       = (grant_idx == TAG_W'(NUM_REQ-1)) ? '0 : grant_idx + TAG_W'(1);
      lut_addr_d  = req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
      issue_tag_d = grant_idx;
      inflight_d[grant_idx] = 1'b1;
    end
    // A returning result never targets a slot that is being consumed or granted.
    if (res_vld) begin
      rsp_valid_d[res_tag] = 1'b1;
      rsp_data_d[int'(res_tag)*DATA_W +: DATA_W] = lut_data;
      inflight_d[res_tag] = 1'b0;
    end
  end

  // Arbiter, issue and result state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q       <= '0;
      lut_en_q    <= 1'b0;
      lut_addr_q  <= '0;
      issue_tag_q <= '0;
      inflight_q  <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      lut_en_q    <= lut_en_d;
      lut_addr_q  <= lut_addr_d;
      issue_tag_q <= issue_tag_d;
      inflight_q  <= inflight_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // Tag pipe advances every cycle. Reset drops whatever is in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_vld_q <= '0;
      for (int k = 0; k < LUT_LAT; k++) begin
        pipe_tag_q[k] <= '0;
      end
    end else begin
      pipe_vld_q[0] <= lut_en_q;
      pipe_tag_q[0] <= issue_tag_q;
      for (int k = 1; k < LUT_LAT; k++) begin
        pipe_vld_q[k] <= pipe_vld_q[k-1];
        pipe_tag_q[k] <= pipe_tag_q[k-1];
      end
    end
  end

  assign lut_en    = lut_en_q;
  assign lut_addr  = lut_addr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = (|inflight_q) | (|rsp_valid_q);

endmodule

// File: tb/tb_lut_neuron_arbiter.sv
// Directed bench for lut_neuron_arbiter.
// The default instance uses LUT_LAT=1; a second instance uses LUT_LAT=3.
module tb_lut_neuron_arbiter;

  logic        clk = 1'b0;
  logic        rst;

  logic [3:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [31:0] req_addr;
  logic        lut_en, busy;
  logic [7:0]  lut_addr, rsp_data;
  logic [1:0]  lut_data, lut_q;

  logic [3:0]  c3_req_valid, c3_req_ready, c3_rsp_valid, c3_rsp_ready;
  logic [31:0] c3_req_addr;
  logic        c3_lut_en, c3_busy;
  logic [7:0]  c3_lut_addr, c3_rsp_data;
  logic [1:0]  c3_lut_data, c3_s0, c3_s1, c3_s2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lut_neuron_arbiter #(.NUM_REQ(4), .ADDR_W(8), .DATA_W(2), .LUT_LAT(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .lut_en(lut_en), .lut_addr(lut_addr), .lut_data(lut_data), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_ready(rsp_ready), .busy(busy)
  );

  lut_neuron_arbiter #(.NUM_REQ(4), .ADDR_W(8), .DATA_W(2), .LUT_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(c3_req_valid), .req_addr(c3_req_addr),
    .req_ready(c3_req_ready), .lut_en(c3_lut_en), .lut_addr(c3_lut_addr),
    .lut_data(c3_lut_data), .rsp_valid(c3_rsp_valid), .rsp_data(c3_rsp_data),
    .rsp_ready(c3_rsp_ready), .busy(c3_busy)
  );

  // Registered LUT models: 0xC3 maps to 01, every other address maps to 00.
  always @(posedge clk) lut_q <= (lut_addr == 8'hC3) ? 2'b01 : 2'b00;
  assign lut_data = lut_q;

  always @(posedge clk) begin
    c3_s0 <= (c3_lut_addr == 8'hC3) ? 2'b01 : 2'b00;
    c3_s1 <= c3_s0;
    c3_s2 <= c3_s1;
  end
  assign c3_lut_data = c3_s2;

  typedef struct {
    logic [3:0]  rv;
    logic [31:0] addr;
    logic [3:0]  rr;
    logic [3:0]  e_ready;
    logic        e_en;
    logic [7:0]  e_addr;
    logic [3:0]  e_rv;
    logic [7:0]  e_rd;
    logic        e_busy;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid    = '0; req_addr    = '0; rsp_ready    = '0;
    c3_req_valid = '0; c3_req_addr = '0; c3_rsp_ready = '0;
  endtask

  // Hold reset over two edges and release it just after an edge with no requests pending.
  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    // Scenario 2: all four requesters valid, addresses C3,00,C3,FF, results always consumed.
    tbl[0] = '{4'hF, 32'hFFC300C3, 4'hF, 4'b0001, 1'b0, 8'h00, 4'b0000, 8'h00, 1'b0};
    tbl[1] = '{4'hF, 32'hFFC300C3, 4'hF, 4'b0010, 1'b1, 8'hC3, 4'b0000, 8'h00, 1'b1};
    tbl[2] = '{4'hF, 32'hFFC300C3, 4'hF, 4'b0100, 1'b1, 8'h00, 4'b0000, 8'h00, 1'b1};
    tbl[3] = '{4'hF, 32'hFFC300C3, 4'hF, 4'b1000, 1'b1, 8'hC3, 4'b0001, 8'h01, 1'b1};
    tbl[4] = '{4'hF, 32'hFFC300C3, 4'hF, 4'b0001, 1'b1, 8'hFF, 4'b0010, 8'h01, 1'b1};
    tbl[5] = '{4'hF, 32'hFFC300C3, 4'hF, 4'b0010, 1'b1, 8'hC3, 4'b0100, 8'h11, 1'b1};
    tbl[6] = '{4'hF, 32'hFFC300C3, 4'hF, 4'b0100, 1'b1, 8'h00, 4'b1000, 8'h11, 1'b1};

    // Reset state.
    idle_inputs();
    rst = 1'b0;
    #12;
    chk("rst_lut_en",    32'(lut_en),    32'h0);
    chk("rst_lut_addr",  32'(lut_addr),  32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_data",  32'(rsp_data),  32'h0);
    chk("rst_busy",      32'(busy),      32'h0);
    $display("reset state checked");

    // Scenario 1: a single request, then a re-grant once the result is consumed.
    do_reset();
    tick(); req_valid = 4'b0001; req_addr = 32'h000000C3; rsp_ready = 4'b0001;
    @(negedge clk); chk("s1_t0_ready", 32'(req_ready), 32'h1);
    tick(); @(negedge clk);
    chk("s1_t1_lut_en",   32'(lut_en),    32'h1);
    chk("s1_t1_lut_addr", 32'(lut_addr),  32'hC3);
    chk("s1_t1_ready",    32'(req_ready), 32'h0);
    tick(); @(negedge clk); chk("s1_t2_rsp_valid", 32'(rsp_valid), 32'h0);
    tick(); @(negedge clk);
    chk("s1_t3_rsp_valid", 32'(rsp_valid),     32'h1);
    chk("s1_t3_rsp_data",  32'(rsp_data[1:0]), 32'h1);
    tick(); @(negedge clk);
    chk("s1_t4_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("s1_t4_regrant",   32'(req_ready), 32'h1);
    $display("scenario 1 single request done");

    // Scenario 2: one table row per cycle.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      tick();
      req_valid = tbl[i].rv; req_addr = tbl[i].addr; rsp_ready = tbl[i].rr;
      @(negedge clk);
      chk($sformatf("s2_v%0d_ready", i),     32'(req_ready), 32'(tbl[i].e_ready));
      chk($sformatf("s2_v%0d_lut_en", i),    32'(lut_en),    32'(tbl[i].e_en));
      chk($sformatf("s2_v%0d_lut_addr", i),  32'(lut_addr),  32'(tbl[i].e_addr));
      chk($sformatf("s2_v%0d_rsp_valid", i), 32'(rsp_valid), 32'(tbl[i].e_rv));
      chk($sformatf("s2_v%0d_rsp_data", i),  32'(rsp_data),  32'(tbl[i].e_rd));
      chk($sformatf("s2_v%0d_busy", i),      32'(busy),      32'(tbl[i].e_busy));
      $display("vector %0d: req_ready=%b lut_en=%b lut_addr=%h rsp_valid=%b rsp_data=%h",
               i, req_ready, lut_en, lut_addr, rsp_valid, rsp_data);
    end

    // Scenario 3: requesters 1 and 3 alternate.
    // Each repeats every four cycles: grant, lookup, result, consume.
    do_reset();
    tick(); req_valid = 4'b1010; req_addr = 32'h00000000; rsp_ready = 4'b1111;
    for (int c = 0; c < 12; c++) begin
      logic [3:0] exp_g;
      if (c > 0) tick();
      @(negedge clk);
      exp_g = (c % 4 == 0) ? 4'b0010 : (c % 4 == 1) ? 4'b1000 : 4'b0000;
      chk($sformatf("s3_c%0d_grant", c), 32'(req_ready), 32'(exp_g));
      chk($sformatf("s3_c%0d_onehot", c), 32'($countones(req_ready) > 1), 32'h0);
    end
    $display("scenario 3 fairness done");

    // Scenario 4: the result is held under backpressure, then the requester is released.
    do_reset();
    tick(); req_valid = 4'b0001; req_addr = 32'h000000C3; rsp_ready = 4'b0000;
    @(negedge clk); chk("s4_t0_ready", 32'(req_ready), 32'h1);
    repeat (3) tick();
    @(negedge clk);
    chk("s4_t3_rsp_valid", 32'(rsp_valid),     32'h1);
    chk("s4_t3_rsp_data",  32'(rsp_data[1:0]), 32'h1);
    for (int c = 0; c < 20; c++) begin
      tick(); @(negedge clk);
      chk($sformatf("s4_hold%0d", c), {22'h0, req_ready, rsp_valid, rsp_data[1:0]},
          {22'h0, 4'b0000, 4'b0001, 2'b01});
    end
    tick(); rsp_ready = 4'b0001;
    @(negedge clk); chk("s4_consume_ready", 32'(req_ready), 32'h0);
    tick(); rsp_ready = 4'b0000;
    @(negedge clk);
    chk("s4_regrant",   32'(req_ready),     32'h1);
    chk("s4_cleared",   32'(rsp_valid),     32'h0);
    chk("s4_data_hold", 32'(rsp_data[1:0]), 32'h1);
    $display("scenario 4 backpressure done");

    // Scenario 5: reset while a lookup is in flight.
    do_reset();
    tick(); req_valid = 4'b0001; req_addr = 32'h000000C3; rsp_ready = 4'b1111;
    @(negedge clk); chk("s5_t0_ready", 32'(req_ready), 32'h1);
    tick();
    chk("s5_pre_lut_en", 32'(lut_en), 32'h1);
    rst = 1'b0; req_valid = 4'b0000;
    #1;
    chk("s5_async_lut_en",   32'(lut_en),    32'h0);
    chk("s5_async_lut_addr", 32'(lut_addr),  32'h0);
    chk("s5_async_busy",     32'(busy),      32'h0);
    chk("s5_async_rsp",      32'(rsp_valid), 32'h0);
    chk("s5_async_ready",    32'(req_ready), 32'h0);
    @(posedge clk); #1 rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick(); @(negedge clk);
      chk($sformatf("s5_quiet%0d", c), {30'h0, rsp_valid != 4'b0, busy}, 32'h0);
    end
    tick(); req_valid = 4'b0011; req_addr = 32'h000000C3;
    @(negedge clk); chk("s5_first_grant", 32'(req_ready), 32'h1);
    $display("scenario 5 reset mid-flight done");

    // Scenario 6: the LUT_LAT=3 instance returns its result five cycles after the grant.
    do_reset();
    tick(); c3_req_valid = 4'b0001; c3_req_addr = 32'h000000C3; c3_rsp_ready = 4'b0001;
    @(negedge clk);
    chk("s6_t0_ready", 32'(c3_req_ready), 32'h1);
    chk("s6_t0_busy",  32'(c3_busy),      32'h0);
    for (int t = 1; t <= 6; t++) begin
      tick();
      if (t == 1) c3_req_valid = 4'b0000;
      @(negedge clk);
      chk($sformatf("s6_t%0d_busy", t),      32'(c3_busy),      32'(t <= 5));
      chk($sformatf("s6_t%0d_rsp_valid", t), 32'(c3_rsp_valid), (t == 5) ? 32'h1 : 32'h0);
      if (t == 5) chk("s6_t5_rsp_data", 32'(c3_rsp_data[1:0]), 32'h1);
    end
    $display("scenario 6 LUT_LAT=3 done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
